// File: rtl/multi_state_stepper.sv
// multi_state_stepper: per-channel synchroniser, debounce filter and rise
// detector driving a wrap / bounce / saturate state counter with clear.
module multi_state_stepper #(
    parameter int CH              = 4,
    parameter int NUM_STATES      = 4,
    parameter int MODE            = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int SW = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1
) (
    input  logic [0:0]         CLK,
    input  logic [0:0]         RST_N,
    input  logic [CH-1:0]      transition,
    input  logic [CH-1:0]      clear,
    output logic [CH*SW-1:0]   state_out,
    output logic [CH-1:0]      changed
);

    localparam int D = DEBOUNCE_CYCLES;
    localparam logic [SW-1:0] S_MAX = SW'(NUM_STATES - 1);
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_w;
        logic                   filt_w;
        logic                   prev_q;
        logic                   rise_w;
        logic [SW-1:0]          state_q;
        logic [SW-1:0]          state_d;
        logic                   dir_q;
        logic                   dir_d;
        logic                   changed_q;
        logic                   changed_d;

        // Metastability chain: input enters at bit 0, leaves at the top bit.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], transition[g]};
            end
        end

        assign sync_w = sync_q[SYNC_STAGES-1];

        if (D > 0) begin : g_db
            localparam int CW = $clog2(D + 1);
            localparam logic [CW-1:0] C_LAST = CW'(D - 1);

            logic          filt_q;
            logic [CW-1:0] cnt_q;

            // Filtered level flips only after D consecutive differing samples.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    filt_q <= 1'b0;
                    cnt_q  <= '0;
                end else if (sync_w == filt_q) begin
                    cnt_q  <= '0;
                end else if (cnt_q == C_LAST) begin
                    filt_q <= sync_w;
                    cnt_q  <= '0;
                end else begin
                    cnt_q  <= cnt_q + CW'(1);
                end
            end

            assign filt_w = filt_q;
        end else begin : g_nodb
            assign filt_w = sync_w;
        end

        // Edge history: previous filtered level for rise detection.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                prev_q <= 1'b0;
            end else begin
                prev_q <= filt_w;
            end
        end

        assign rise_w = filt_w & ~prev_q;

        // State register: counter value, bounce direction and change pulse.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                state_q   <= '0;
                dir_q     <= DIR_UP;
                changed_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                dir_q     <= dir_d;
                changed_q <= changed_d;
            end
        end

        // Next state: clear wins over a coincident step, which is dropped.
        always_comb begin
            state_d = state_q;
            dir_d   = dir_q;
            if (clear[g]) begin
                state_d = '0;
                dir_d   = DIR_UP;
            end else if (rise_w) begin
                if (MODE == 1) begin
                    if (dir_q == DIR_UP) begin
                        if (state_q == S_MAX) begin
                            state_d = state_q - SW'(1);
                            dir_d   = DIR_DN;
                        end else begin
                            state_d = state_q + SW'(1);
                        end
                    end else begin
                        if (state_q == '0) begin
                            state_d = SW'(1);
                            dir_d   = DIR_UP;
                        end else begin
                            state_d = state_q - SW'(1);
                        end
                    end
                end else if (MODE == 2) begin
                    if (state_q != S_MAX) begin
                        state_d = state_q + SW'(1);
                    end
                end else begin
                    if (state_q == S_MAX) begin
                        state_d = '0;
                    end else begin
                        state_d = state_q + SW'(1);
                    end
                end
            end
        end

        // Outputs: flag a change only when the stored value really moves.
        always_comb begin
            changed_d = (state_d != state_q);
        end

        assign state_out[g*SW +: SW] = state_q;
        assign changed[g]            = changed_q;
    end

endmodule

// File: tb/tb_multi_state_stepper.sv
// tb_multi_state_stepper: four configurations driven with shared stimulus,
// checked every cycle against a history-based model plus literal anchors.
module tb_multi_state_stepper;

    localparam int S    = 2;
    localparam int HMAX = 8192;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] tr;
    logic [3:0] clr;
    logic [7:0] so0, so1, so2;
    logic [3:0] cg0, cg1, cg2;
    logic [1:0] so3, cg3;

    always #5 CLK = ~CLK;

    multi_state_stepper u0 (
        .CLK(CLK), .RST_N(RST_N), .transition(tr), .clear(clr),
        .state_out(so0), .changed(cg0));

    multi_state_stepper #(.MODE(1)) u1 (
        .CLK(CLK), .RST_N(RST_N), .transition(tr), .clear(clr),
        .state_out(so1), .changed(cg1));

    multi_state_stepper #(.MODE(2)) u2 (
        .CLK(CLK), .RST_N(RST_N), .transition(tr), .clear(clr),
        .state_out(so2), .changed(cg2));

    multi_state_stepper #(.CH(2), .NUM_STATES(2), .MODE(0),
                          .DEBOUNCE_CYCLES(0)) u3 (
        .CLK(CLK), .RST_N(RST_N), .transition(tr[1:0]), .clear(clr[1:0]),
        .state_out(so3), .changed(cg3));

    int checks   = 0;
    int failures = 0;

    int cfg_n  [4] = '{4, 4, 4, 2};
    int cfg_m  [4] = '{0, 1, 2, 0};
    int cfg_d  [4] = '{4, 4, 4, 0};
    int cfg_ch [4] = '{4, 4, 4, 2};

    bit hist [4][HMAX];
    int n_edge = 0;
    int base   = 1 << 30;

    bit mf    [4][4];
    bit mprev [4][4];
    bit mchg  [4][4];
    int mst   [4][4];
    int mph   [4][4];

    int exp_wrap [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int exp_bnc  [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int exp_sat  [8] = '{1, 2, 3, 3, 3, 3, 3, 3};

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit sync_at(int c, int n);
        int m;
        m = n - S;
        if (m < 0 || m < base) return 1'b0;
        return hist[c][m];
    endfunction

    task automatic model_reset();
        base = 1 << 30;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                mf[d][c]    = 1'b0;
                mprev[d][c] = 1'b0;
                mchg[d][c]  = 1'b0;
                mst[d][c]   = 0;
                mph[d][c]   = 0;
            end
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 4; c++) hist[c][n_edge] = tr[c];
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < cfg_ch[d]; c++) begin
                bit s;
                bit fcur;
                bit rise;
                bit allf;
                int old;
                s    = sync_at(c, n_edge);
                fcur = (cfg_d[d] == 0) ? s : mf[d][c];
                rise = fcur && !mprev[d][c];
                mprev[d][c] = fcur;
                if (cfg_d[d] > 0) begin
                    allf = 1'b1;
                    for (int k = 0; k < cfg_d[d]; k++)
                        if (sync_at(c, n_edge - k) == mf[d][c]) allf = 1'b0;
                    if (allf) mf[d][c] = !mf[d][c];
                end
                old = mst[d][c];
                if (clr[c]) begin
                    mst[d][c] = 0;
                    mph[d][c] = 0;
                end else if (rise) begin
                    case (cfg_m[d])
                        0: mst[d][c] = (mst[d][c] + 1) % cfg_n[d];
                        1: begin
                            mph[d][c] = (mph[d][c] + 1) % (2 * cfg_n[d] - 2);
                            mst[d][c] = (mph[d][c] < cfg_n[d]) ? mph[d][c]
                                      : 2 * cfg_n[d] - 2 - mph[d][c];
                        end
                        default: if (mst[d][c] < cfg_n[d] - 1) mst[d][c]++;
                    endcase
                end
                mchg[d][c] = (mst[d][c] != old);
            end
        end
    endtask

    function automatic logic [31:0] dut_st(int d, int c);
        case (d)
            0:       return {30'b0, so0[c*2 +: 2]};
            1:       return {30'b0, so1[c*2 +: 2]};
            2:       return {30'b0, so2[c*2 +: 2]};
            default: return {31'b0, so3[c]};
        endcase
    endfunction

    function automatic logic [31:0] dut_cg(int d, int c);
        case (d)
            0:       return {31'b0, cg0[c]};
            1:       return {31'b0, cg1[c]};
            2:       return {31'b0, cg2[c]};
            default: return {31'b0, cg3[c]};
        endcase
    endfunction

    task automatic compare_all();
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < cfg_ch[d]; c++) begin
                chk($sformatf("u%0d.state[%0d]", d, c),
                    dut_st(d, c), mst[d][c]);
                chk($sformatf("u%0d.changed[%0d]", d, c),
                    dut_cg(d, c), {31'b0, mchg[d][c]});
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST_N) model_edge();
        n_edge++;
        #1;
        compare_all();
        @(negedge CLK);
    endtask

    int hold [4];

    initial begin
        RST_N = 1'b0;
        tr    = '0;
        clr   = '0;
        model_reset();
        repeat (3) tick();
        chk("reset_u0", so0, 0);
        chk("reset_u3", {so3, cg3}, 0);
        RST_N = 1'b1;
        base  = n_edge;

        // ch0: 8 clean rises, latency k+6, one-cycle change pulse
        for (int r = 0; r < 8; r++) begin
            tr = 4'b0001;
            repeat (6) tick();
            chk("lat_hold", so0[1:0], (r == 0) ? 0 : exp_wrap[r-1]);
            tick();
            chk("wrap_step", so0[1:0], exp_wrap[r]);
            chk("wrap_chg", cg0[0], 1);
            chk("bounce_step", so1[1:0], exp_bnc[r]);
            chk("sat_step", so2[1:0], exp_sat[r]);
            chk("sat_chg", cg2[0], (r < 3) ? 1 : 0);
            chk("others_zero", so0[7:2], 0);
            tick();
            chk("chg_pulse", cg0[0], 0);
            repeat (12) tick();
            tr = 4'b0000;
            repeat (20) tick();
        end

        // ch1 glitch rejection
        tr = 4'b0010;
        repeat (3) tick();
        tr = 4'b0000;
        repeat (15) tick();
        chk("glitch3", so0[3:2], 0);
        tr = 4'b0010;
        repeat (4) tick();
        tr = 4'b0000;
        repeat (15) tick();
        chk("pulse4", so0[3:2], 1);
        tr = 4'b0010;
        repeat (8) tick();
        tr = 4'b0000;
        repeat (2) tick();
        tr = 4'b0010;
        repeat (10) tick();
        tr = 4'b0000;
        repeat (20) tick();
        chk("dropout", so0[3:2], 2);

        // ch2 clear coinciding with a step edge
        for (int r = 0; r < 3; r++) begin
            tr = 4'b0100;
            repeat (10) tick();
            tr = 4'b0000;
            repeat (10) tick();
        end
        chk("pre_clear", so0[5:4], 3);
        tr = 4'b0100;
        repeat (6) tick();
        clr = 4'b0100;
        tick();
        chk("clr_state", so0[5:4], 0);
        chk("clr_chg", cg0[2], 1);
        chk("clr_bnc", so1[5:4], 0);
        clr = 4'b0000;
        tick();
        chk("clr_no_defer", so0[5:4], 0);
        chk("clr_chg_once", cg0[2], 0);
        repeat (12) tick();
        tr = 4'b0000;
        repeat (10) tick();
        clr = 4'b0100;
        tick();
        chk("clr_at_zero", cg0[2], 0);
        clr = 4'b0000;
        tick();
        tr = 4'b0100;
        repeat (7) tick();
        chk("bnc_after_clr", so1[5:4], 1);
        tr = 4'b0000;
        repeat (13) tick();

        // reset while ch3 debounce counter is mid-count
        tr = 4'b1000;
        repeat (4) tick();
        RST_N = 1'b0;
        #1;
        chk("async_rst_so", {so0, so1, so2, so3}, 0);
        chk("async_rst_cg", {cg0, cg1, cg2, cg3}, 0);
        model_reset();
        tick();
        RST_N = 1'b1;
        base  = n_edge;
        repeat (6) tick();
        chk("rel_hold", so0[7:6], 0);
        tick();
        chk("rel_step", so0[7:6], 1);
        chk("rel_chg", cg0[3], 1);

        // two-state, no-filter instance: simultaneous toggles
        tr = 4'b1011;
        repeat (2) tick();
        chk("u3_hold", so3, 0);
        tick();
        chk("u3_both", so3, 2'b11);
        chk("u3_chg", cg3, 2'b11);
        tick();
        chk("u3_chg_off", cg3, 0);
        repeat (6) tick();
        tr = 4'b1000;
        repeat (6) tick();
        tr = 4'b1011;
        repeat (3) tick();
        chk("u3_back", so3, 0);
        chk("u3_chg2", cg3, 2'b11);
        tr = 4'b0000;
        repeat (20) tick();

        // randomized levels, clears and one mid-run reset
        for (int c = 0; c < 4; c++) hold[c] = 1;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 4; c++) begin
                hold[c]--;
                if (hold[c] == 0) begin
                    tr[c]   = ~tr[c];
                    hold[c] = $urandom_range(1, 12);
                end
            end
            clr = '0;
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 49) == 0) clr[c] = 1'b1;
            if (i == 1500) begin
                RST_N = 1'b0;
                model_reset();
            end
            if (i == 1502) begin
                RST_N = 1'b1;
                base  = n_edge;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
